// File: rtl/barrel_unrotate.sv
// Right-rotating barrel register: accepts a word and a rotation count, rotates right one bit
// per clock to undo an upstream left rotation, then holds the result for the consumer.
module barrel_unrotate #(
   parameter int word_size  = 4,
   parameter int count_size = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [word_size-1:0]  Data_in,
   input  logic [count_size-1:0] Rot_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [word_size-1:0]  Data_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [count_size-1:0] rem;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // rem==1 marks the last shift; rem==0 inside SHIFT is unreachable but exits safely
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               next_state = (Rot_in == '0) ? HOLD : SHIFT;
            end
         end
         SHIFT: begin
            if (rem <= count_size'(1)) begin
               next_state = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         Data_out <= '0;
         rem      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  Data_out <= Data_in;
                  rem      <= Rot_in;
               end
            end
            SHIFT: begin
               Data_out <= {Data_out[0], Data_out[word_size-1:1]};
               rem      <= rem - count_size'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == HOLD);
   assign busy      = (state == SHIFT);

endmodule
